prefix_operand_stage: RTL and testbench

Registered pre-processing stage sitting directly upstream of the parallel-prefix carry network. Accepts operand pairs with a valid/ready handshake and applies subtract inversion. Produces the bitwise propagate/generate vectors, including the carry-in-1 generate variant consumed by the double prefix nodes. Includes a 2-entry skid buffer so full throughput is kept under downstream backpressure.

---
 rtl/prefix_operand_stage.sv | 120 ++++++++++++
 tb/tb_prefix_operand_stage.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prefix_operand_stage.sv
// Operand pre-processing stage ahead of the parallel-prefix carry network: subtract inversion,
// p/g/g' generation, 2-entry skid buffer. Optional parity output via PREFIX_OPERAND_STAGE_PARITY_EN.
module prefix_operand_stage #(
    parameter int WIDTH       = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock_signal,
    input  logic                   reset_signal,
    input  logic [WIDTH-1:0]       operand_a,
    input  logic [WIDTH-1:0]       operand_b,
    input  logic                   subtract_signal,
    input  logic                   input_valid,
    output logic                   input_ready,
    output logic [WIDTH-1:0]       pi_out,
    output logic [WIDTH-1:0]       gi_out,
    output logic [WIDTH-1:0]       gi_prim_out,
    output logic                   carry_in_out,
    output logic                   output_valid,
    input  logic                   output_ready,
    output logic [COUNT_WIDTH-1:0] transaction_count
`ifdef PREFIX_OPERAND_STAGE_PARITY_EN
    ,
    output logic                   p_parity_out
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] p;
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] gp;
        logic             c;
`ifdef PREFIX_OPERAND_STAGE_PARITY_EN
        logic             par;
`endif
    } payload_t;

    logic [WIDTH-1:0]       b_mod;
    logic [WIDTH-1:0]       p_vec;
    logic [WIDTH-1:0]       g_vec;
    payload_t               in_pl;
    payload_t               out_pl;
    payload_t               skid_pl;
    logic                   out_valid;
    logic                   skid_valid;
    logic                   accept;
    logic                   transfer;
    logic [COUNT_WIDTH-1:0] count;

    assign b_mod = operand_b ^ {WIDTH{subtract_signal}};
    assign p_vec = operand_a ^ b_mod;
    assign g_vec = operand_a & b_mod;

    always_comb begin
        in_pl     = '0;
        in_pl.p   = p_vec;
        in_pl.g   = g_vec;
        in_pl.gp  = {g_vec[WIDTH-1:1], g_vec[0] | p_vec[0]};
        in_pl.c   = subtract_signal;
`ifdef PREFIX_OPERAND_STAGE_PARITY_EN
        in_pl.par = ^p_vec;
`endif
    end

    // Ready comes from the skid flag only, so output_ready never reaches input_ready.
    assign input_ready  = !skid_valid && !reset_signal;
    assign output_valid = out_valid && !reset_signal;
    assign accept       = input_valid && input_ready;
    assign transfer     = output_valid && output_ready;

    always_ff @(posedge clock_signal) begin
        if (reset_signal) begin
            out_valid  <= 1'b0;
            skid_valid <= 1'b0;
            out_pl     <= '0;
            skid_pl    <= '0;
            count      <= '0;
        end else begin
            if (accept) begin
                count <= count + COUNT_WIDTH'(1);
            end
            case ({out_valid, skid_valid})
                2'b00: begin
                    if (accept) begin
                        out_pl    <= in_pl;
                        out_valid <= 1'b1;
                    end
                end
                2'b10: begin
                    if (accept && transfer) begin
                        out_pl <= in_pl;
                    end else if (transfer) begin
                        out_valid <= 1'b0;
                    end else if (accept) begin
                        skid_pl    <= in_pl;
                        skid_valid <= 1'b1;
                    end
                end
                2'b11: begin
                    if (transfer) begin
                        out_pl     <= skid_pl;
                        skid_valid <= 1'b0;
                    end
                end
                default: begin
                    skid_valid <= 1'b0;
                end
            endcase
        end
    end

    assign pi_out            = out_pl.p;
    assign gi_out            = out_pl.g;
    assign gi_prim_out       = out_pl.gp;
    assign carry_in_out      = out_pl.c;
    assign transaction_count = count;
`ifdef PREFIX_OPERAND_STAGE_PARITY_EN
    assign p_parity_out      = out_pl.par;
`endif

endmodule

// File: tb/tb_prefix_operand_stage.sv
// Bench for prefix_operand_stage: directed vectors plus randomized traffic against a 2-deep FIFO model.
module tb_prefix_operand_stage;

    logic       clock_signal = 1'b0;
    logic       reset_signal;
    logic [7:0] operand_a, operand_b;
    logic       subtract_signal, input_valid, output_ready;
    logic       input_ready, carry_in_out, output_valid;
    logic [7:0] pi_out, gi_out, gi_prim_out;
    logic [15:0] transaction_count;
    logic       ir4, cy4, ov4;
    logic [7:0] pi4, gi4, gp4;
    logic [3:0] count4;
`ifdef PREFIX_OPERAND_STAGE_PARITY_EN
    logic       p_parity_out, par4;
`endif

    prefix_operand_stage #(.WIDTH(8), .COUNT_WIDTH(16)) dut (
        .clock_signal(clock_signal), .reset_signal(reset_signal),
        .operand_a(operand_a), .operand_b(operand_b), .subtract_signal(subtract_signal),
        .input_valid(input_valid), .input_ready(input_ready),
        .pi_out(pi_out), .gi_out(gi_out), .gi_prim_out(gi_prim_out), .carry_in_out(carry_in_out),
        .output_valid(output_valid), .output_ready(output_ready),
        .transaction_count(transaction_count)
`ifdef PREFIX_OPERAND_STAGE_PARITY_EN
        , .p_parity_out(p_parity_out)
`endif
    );

    prefix_operand_stage #(.WIDTH(8), .COUNT_WIDTH(4)) dut4 (
        .clock_signal(clock_signal), .reset_signal(reset_signal),
        .operand_a(operand_a), .operand_b(operand_b), .subtract_signal(subtract_signal),
        .input_valid(input_valid), .input_ready(ir4),
        .pi_out(pi4), .gi_out(gi4), .gi_prim_out(gp4), .carry_in_out(cy4),
        .output_valid(ov4), .output_ready(output_ready),
        .transaction_count(count4)
`ifdef PREFIX_OPERAND_STAGE_PARITY_EN
        , .p_parity_out(par4)
`endif
    );

    always #5 clock_signal = ~clock_signal;

    typedef struct {
        logic [7:0] p, g, gp;
        logic       c, par;
    } txn_t;

    txn_t q[$];
    int   cnt;
    int   checks = 0;
    int   errors = 0;

    // Adder pre-processing from its arithmetic definition.
    function automatic txn_t ref_model(input logic [7:0] a, input logic [7:0] b, input logic sub);
        txn_t t;
        logic [7:0] bb;
        bb    = sub ? ~b : b;
        t.p   = a ^ bb;
        t.g   = a & bb;
        t.gp  = t.g | {7'b0, t.p[0]};
        t.c   = sub;
        t.par = ^t.p;
        return t;
    endfunction

    // Stage behaves as a 2-deep FIFO: ready while fewer than 2 held, valid while any held.
    task automatic tick();
        bit acc, xf;
        acc = input_valid && (q.size() < 2) && !reset_signal;
        xf  = output_ready && (q.size() > 0) && !reset_signal;
        if (reset_signal) begin
            q.delete();
            cnt = 0;
        end else begin
            if (xf) void'(q.pop_front());
            if (acc) begin
                q.push_back(ref_model(operand_a, operand_b, subtract_signal));
                cnt++;
            end
        end
        @(posedge clock_signal);
        #1;
    endtask

    task automatic test_reset();
        reset_signal = 1'b1; input_valid = 1'b0; output_ready = 1'b1;
        operand_a = 'x; operand_b = 'x; subtract_signal = 1'b0;
        tick(); tick();
        checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL reset_ovalid got %b want 0", output_valid); end
        checks++; if (input_ready !== 1'b0) begin errors++; $display("FAIL reset_iready got %b want 0", input_ready); end
        checks++; if ({pi_out, gi_out, gi_prim_out, carry_in_out} !== 25'd0) begin errors++;
            $display("FAIL reset_data got %h %h %h %b want 0", pi_out, gi_out, gi_prim_out, carry_in_out); end
        checks++; if (transaction_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", transaction_count); end
`ifdef PREFIX_OPERAND_STAGE_PARITY_EN
        checks++; if (p_parity_out !== 1'b0) begin errors++; $display("FAIL reset_parity got %b want 0", p_parity_out); end
`endif
        reset_signal = 1'b0; #1;
        checks++; if (input_ready !== 1'b1) begin errors++; $display("FAIL post_reset_iready got %b want 1", input_ready); end
    endtask

    task automatic test_add_vector();
        operand_a = 8'h5A; operand_b = 8'h33; subtract_signal = 1'b0; input_valid = 1'b1; output_ready = 1'b1;
        tick();
        input_valid = 1'b0; operand_a = 'x; operand_b = 'x;
        checks++; if (output_valid !== 1'b1) begin errors++; $display("FAIL add_ovalid got %b want 1", output_valid); end
        checks++; if ({pi_out, gi_out, gi_prim_out, carry_in_out} !== {8'h69, 8'h12, 8'h13, 1'b0}) begin errors++;
            $display("FAIL add_data got %h %h %h %b want 69 12 13 0", pi_out, gi_out, gi_prim_out, carry_in_out); end
        checks++; if (transaction_count !== 16'd1) begin errors++; $display("FAIL add_count got %0d want 1", transaction_count); end
`ifdef PREFIX_OPERAND_STAGE_PARITY_EN
        checks++; if (p_parity_out !== 1'b0) begin errors++; $display("FAIL add_parity got %b want 0", p_parity_out); end
        tick();
        operand_a = 8'h01; operand_b = 8'h00; input_valid = 1'b1;
        tick();
        input_valid = 1'b0;
        checks++; if (p_parity_out !== 1'b1) begin errors++; $display("FAIL parity_one got %b want 1", p_parity_out); end
`endif
        tick();
        checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL add_drain got %b want 0", output_valid); end
    endtask

    task automatic test_sub_vector();
        operand_a = 8'h10; operand_b = 8'h01; subtract_signal = 1'b1; input_valid = 1'b1; output_ready = 1'b1;
        tick();
        input_valid = 1'b0; subtract_signal = 1'b0;
        checks++; if ({output_valid, pi_out, gi_out, gi_prim_out, carry_in_out} !== {1'b1, 8'hEE, 8'h10, 8'h10, 1'b1}) begin
            errors++; $display("FAIL sub_data got %b %h %h %h %b want 1 ee 10 10 1",
                               output_valid, pi_out, gi_out, gi_prim_out, carry_in_out); end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] va[3] = '{8'h11, 8'h80, 8'hF0};
        logic [7:0] vb[3] = '{8'h22, 8'h7F, 8'h0F};
        logic       vs[3] = '{1'b0, 1'b1, 1'b0};
        txn_t       ex;
        output_ready = 1'b0; input_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            operand_a = va[i]; operand_b = vb[i]; subtract_signal = vs[i];
            checks++; if (input_ready !== (i < 2)) begin errors++;
                $display("FAIL bp_iready[%0d] got %b want %b", i, input_ready, i < 2); end
            tick();
        end
        checks++; if (input_ready !== 1'b0) begin errors++; $display("FAIL bp_held got %b want 0", input_ready); end
        output_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ex = ref_model(va[k], vb[k], vs[k]);
            checks++; if (output_valid !== 1'b1 || {pi_out, gi_out, gi_prim_out, carry_in_out} !== {ex.p, ex.g, ex.gp, ex.c}) begin
                errors++; $display("FAIL bp_order[%0d] got %b %h %h %h %b want 1 %h %h %h %b", k, output_valid,
                                   pi_out, gi_out, gi_prim_out, carry_in_out, ex.p, ex.g, ex.gp, ex.c); end
            tick();
            if (k == 0) begin
                checks++; if (input_ready !== 1'b1) begin errors++; $display("FAIL bp_reready got %b want 1", input_ready); end
            end
            if (k == 1) input_valid = 1'b0;
        end
        checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", output_valid); end
        checks++; if (transaction_count !== 16'(cnt)) begin errors++;
            $display("FAIL bp_count got %0d want %0d", transaction_count, 16'(cnt)); end
    endtask

    task automatic test_reset_mid();
        txn_t ex;
        output_ready = 1'b0; input_valid = 1'b1; subtract_signal = 1'b0;
        operand_a = 8'h0F; operand_b = 8'h01; tick();
        operand_a = 8'hAA; operand_b = 8'h55; tick();
        input_valid = 1'b0;
        reset_signal = 1'b1; output_ready = 1'b1;
        #1;
        checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_xfer got %b want 0", output_valid); end
        tick();
        checks++; if ({output_valid, input_ready, transaction_count} !== 18'd0) begin errors++;
            $display("FAIL rmid_state got %b %b %0d want 0 0 0", output_valid, input_ready, transaction_count); end
        reset_signal = 1'b0; #1;
        checks++; if (input_ready !== 1'b1) begin errors++; $display("FAIL rmid_iready got %b want 1", input_ready); end
        operand_a = 8'h3C; operand_b = 8'h0C; subtract_signal = 1'b1; input_valid = 1'b1;
        ex = ref_model(8'h3C, 8'h0C, 1'b1);
        tick();
        input_valid = 1'b0;
        checks++; if (output_valid !== 1'b1 || {pi_out, gi_out, gi_prim_out, carry_in_out} !== {ex.p, ex.g, ex.gp, ex.c}) begin
            errors++; $display("FAIL rmid_first got %b %h %h %h %b want 1 %h %h %h %b", output_valid,
                               pi_out, gi_out, gi_prim_out, carry_in_out, ex.p, ex.g, ex.gp, ex.c); end
        tick();
    endtask

    task automatic test_count_wrap();
        reset_signal = 1'b1; tick(); reset_signal = 1'b0;
        output_ready = 1'b1; input_valid = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            operand_a = 8'($urandom); operand_b = 8'($urandom); subtract_signal = 1'($urandom);
            tick();
            if (i == 16) begin
                checks++; if (count4 !== 4'd0) begin errors++; $display("FAIL wrap16 got %0d want 0", count4); end
            end
        end
        input_valid = 1'b0;
        checks++; if (count4 !== 4'd1) begin errors++; $display("FAIL wrap17 got %0d want 1", count4); end
        checks++; if (transaction_count !== 16'd17) begin errors++; $display("FAIL count17 got %0d want 17", transaction_count); end
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            input_valid  = ($urandom_range(0, 3) != 0);
            output_ready = ($urandom_range(0, 2) != 0);
            subtract_signal = 1'($urandom);
            if (input_valid) begin
                operand_a = 8'($urandom); operand_b = 8'($urandom);
            end else begin
                operand_a = 'x; operand_b = 'x;
            end
            checks++; if (output_valid !== (q.size() > 0) || input_ready !== (q.size() < 2)) begin errors++;
                $display("FAIL rnd_hs[%0d] got v=%b r=%b want v=%b r=%b", n, output_valid, input_ready,
                         q.size() > 0, q.size() < 2); end
            if (q.size() > 0) begin
                checks++; if ({pi_out, gi_out, gi_prim_out, carry_in_out} !== {q[0].p, q[0].g, q[0].gp, q[0].c}) begin
                    errors++; $display("FAIL rnd_data[%0d] got %h %h %h %b want %h %h %h %b", n,
                                       pi_out, gi_out, gi_prim_out, carry_in_out, q[0].p, q[0].g, q[0].gp, q[0].c); end
`ifdef PREFIX_OPERAND_STAGE_PARITY_EN
                checks++; if (p_parity_out !== q[0].par) begin errors++;
                    $display("FAIL rnd_parity[%0d] got %b want %b", n, p_parity_out, q[0].par); end
`endif
            end
            checks++; if (transaction_count !== 16'(cnt) || count4 !== 4'(cnt)) begin errors++;
                $display("FAIL rnd_count[%0d] got %0d/%0d want %0d/%0d", n, transaction_count, count4, 16'(cnt), 4'(cnt)); end
            tick();
        end
        input_valid = 1'b0;
    endtask

    initial begin
        cnt = 0;
        test_reset();
        test_add_vector();
        test_sub_vector();
        test_back_to_back();
        test_reset_mid();
        test_count_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
